// File: rtl/mm_tile_sched_if.sv
// Command/status and mesh-edge bundle for the systolic tile scheduler.
// Latency: n/a (signal bundle only).
// Backpressure: none; the scheduler ignores start while busy.
interface mm_tile_sched_if #(
  parameter int N  = 4,
  parameter int KW = 9
);
  // command side
  logic          start;
  logic [KW-1:0] k_len;
  logic          abort;
  // operand buffer read port
  logic          rd_en;
  logic [KW-1:0] rd_k;
  // mesh edge controls
  logic [N-1:0]  a_valid_edge;
  logic [N-1:0]  b_valid_edge;
  logic          acc_clear;
  logic [N-1:0]  drain_edge;
  // status
  logic          busy;
  logic          done;

  // master: the command issuer (top level / bench)
  modport master (
    output start, k_len, abort,
    input  rd_en, rd_k, a_valid_edge, b_valid_edge, acc_clear, drain_edge, busy, done
  );

  // slave: the scheduler itself
  modport slave (
    input  start, k_len, abort,
    output rd_en, rd_k, a_valid_edge, b_valid_edge, acc_clear, drain_edge, busy, done
  );
endinterface

// File: rtl/mm_tile_sched.sv
// Per-tile sequencer for the NxN MAC mesh: clear, stream K operands, skew valids, flush, drain, wait.
// Latency: done pulses k_len + F + N + 3 cycles after start, F = RD_LAT + 2(N-1) + PIPE_MUL + 1.
// Backpressure: none; start is only accepted in IDLE, abort returns to IDLE on the next edge.
module mm_tile_sched #(
  parameter int N        = 4,
  parameter int K_MAX    = 256,
  parameter int KW       = $clog2(K_MAX + 1),
  parameter int RD_LAT   = 1,
  parameter int PIPE_MUL = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  mm_tile_sched_if.slave  bus
);

  // Flush length: operand read latency, wavefront travel to PE(N-1,N-1),
  // optional product register, plus the final accumulate.
  localparam int F       = RD_LAT + 2 * (N - 1) + PIPE_MUL + 1;
  localparam int CNT_MAX = (F > N) ? F : N;
  localparam int CW      = $clog2(CNT_MAX + 1);
  // Deepest tap of the valid skew line (row/column N-1).
  localparam int SRD     = RD_LAT + N - 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLEAR  = 3'd1;
  localparam logic [2:0] STREAM = 3'd2;
  localparam logic [2:0] FLUSH  = 3'd3;
  localparam logic [2:0] DRAIN  = 3'd4;
  localparam logic [2:0] DWAIT  = 3'd5;

  logic [2:0]    state;
  logic [2:0]    nxt;
  logic [KW-1:0] k_lat;
  logic [KW-1:0] k_in;
  logic [KW-1:0] k_last;
  logic [CW-1:0] cnt;

  logic          rd_en_q;
  logic [KW-1:0] rd_k_q;
  logic [SRD:1]  sr;
  logic [N-1:0]  valid_skew;
  logic          acc_clear_q;
  logic [N-1:0]  drain_q;
  logic          busy_q;
  logic          done_q;

  // Out-of-range lengths are clamped so the read index can never run past K_MAX-1.
  assign k_in   = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;
  assign k_last = k_lat - KW'(1);

  // Next-state decode; abort overrides every other transition, including start.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.start) nxt = CLEAR;
      CLEAR:   nxt = (k_lat == '0) ? FLUSH : STREAM;
      STREAM:  if (rd_k_q == k_last) nxt = FLUSH;
      FLUSH:   if (cnt == '0) nxt = DRAIN;
      DRAIN:   nxt = DWAIT;
      DWAIT:   if (cnt == '0) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (bus.abort) nxt = IDLE;
  end

  // State register and the tile length captured at start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k_lat <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.start && !bus.abort) k_lat <= k_in;
    end
  end

  // Shared down-counter: loaded with F-1 entering FLUSH and N-1 entering DWAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (bus.abort) begin
      cnt <= '0;
    end else if (state != FLUSH && nxt == FLUSH) begin
      cnt <= CW'(F - 1);
    end else if (state != DWAIT && nxt == DWAIT) begin
      cnt <= CW'(N - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Read strobe and index, registered from the next state; index is 0 outside STREAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q <= 1'b0;
      rd_k_q  <= '0;
    end else begin
      rd_en_q <= (nxt == STREAM);
      if (nxt == STREAM) rd_k_q <= (state == STREAM) ? rd_k_q + KW'(1) : '0;
      else               rd_k_q <= '0;
    end
  end

  // Valid skew line: tap d carries rd_en delayed by d cycles; cleared by abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (bus.abort) begin
      sr <= '0;
    end else begin
      sr[1] <= rd_en_q;
      for (int d = 2; d <= SRD; d++) sr[d] <= sr[d-1];
    end
  end

  // Row/column i sees the operand RD_LAT+i cycles after its read strobe.
  for (genvar i = 0; i < N; i++) begin : g_skew
    assign valid_skew[i] = sr[RD_LAT + i];
  end

  // Mesh control strobes and status, all registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_clear_q <= 1'b0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      acc_clear_q <= (nxt == CLEAR);
      drain_q     <= {N{nxt == DRAIN}};
      busy_q      <= (nxt != IDLE);
      done_q      <= (state == DWAIT) && (cnt == '0) && !bus.abort;
    end
  end

  assign bus.rd_en        = rd_en_q;
  assign bus.rd_k         = rd_k_q;
  assign bus.a_valid_edge = valid_skew;
  assign bus.b_valid_edge = valid_skew;
  assign bus.acc_clear    = acc_clear_q;
  assign bus.drain_edge   = drain_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_mm_tile_sched.sv
// Bench for mm_tile_sched: two instances (RD_LAT=1/PIPE_MUL=0 and RD_LAT=2/PIPE_MUL=1) share stimulus.
// Latency: every cycle's outputs are compared against a tile-timeline model.
// Backpressure: n/a.
module tb_mm_tile_sched;
  localparam int N   = 4;
  localparam int KW  = 9;
  localparam int INF = 1 << 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mm_tile_sched_if #(.N(N), .KW(KW)) if0 ();
  mm_tile_sched_if #(.N(N), .KW(KW)) if1 ();

  mm_tile_sched #(.N(N), .K_MAX(256), .KW(KW), .RD_LAT(1), .PIPE_MUL(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  mm_tile_sched #(.N(N), .K_MAX(256), .KW(KW), .RD_LAT(2), .PIPE_MUL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));

  // A tile as seen by the model: which DUT, start cycle, length, abort cycle.
  typedef struct {
    int d;
    int t0;
    int k;
    int cut;
  } tile_t;

  tile_t tq[$];
  int cyc;
  int n_chk;
  int n_pass;
  int done_cnt [2];
  int last_done [2];
  int last_drain [2];
  int last_clear [2];
  int max_rdk [2];
  int t0;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int fdel(input int d);
    return lat(d) + 2 * (N - 1) + ((d == 0) ? 0 : 1) + 1;
  endfunction

  // Expected outputs {busy,done,clr,rd_en,rd_k,a_valid,b_valid,drain} at cycle c, from the
  // timeline of every tile started on DUT d (offset o = c - start cycle).
  function automatic logic [24:0] model_outs(input int d, input int c);
    logic       busy, done, clr, rd;
    logic [8:0] rk;
    logic [3:0] va, dr;
    int o, k, f, sk;
    busy = 0; done = 0; clr = 0; rd = 0; rk = '0; va = '0; dr = '0;
    foreach (tq[i]) begin
      if (tq[i].d == d && c >= tq[i].t0 && c <= tq[i].cut) begin
        o = c - tq[i].t0;
        k = tq[i].k;
        f = fdel(d);
        if (o >= 1 && o <= k + f + N + 2) busy = 1;
        if (o == k + f + N + 3) done = 1;
        if (o == 1) clr = 1;
        if (o >= 2 && o <= k + 1) begin
          rd = 1;
          rk = 9'(o - 2);
        end
        for (int r = 0; r < N; r++) begin
          sk = o - lat(d) - r;
          if (sk >= 2 && sk <= k + 1) va[r] = 1;
        end
        if (o == k + f + 2) dr = '1;
      end
    end
    return {busy, done, clr, rd, rk, va, va, dr};
  endfunction

  function automatic logic [24:0] obs(input int d);
    if (d == 0)
      return {if0.busy, if0.done, if0.acc_clear, if0.rd_en, if0.rd_k,
              if0.a_valid_edge, if0.b_valid_edge, if0.drain_edge};
    return {if1.busy, if1.done, if1.acc_clear, if1.rd_en, if1.rd_k,
            if1.a_valid_edge, if1.b_valid_edge, if1.drain_edge};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // One cycle: compare both DUTs with the model, then drive this cycle's inputs.
  task automatic step(input logic s, input logic [8:0] k, input logic ab);
    logic [24:0] got, exp;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      got = obs(d);
      exp = model_outs(d, cyc);
      check($sformatf("outs_d%0d_c%0d", d, cyc), 64'(got), 64'(exp));
      if (got[23]) begin
        done_cnt[d]++;
        last_done[d] = cyc;
      end
      if (got[22]) last_clear[d] = cyc;
      if (got[3:0] != 4'd0) last_drain[d] = cyc;
      if (got[21] && int'(got[20:12]) > max_rdk[d]) max_rdk[d] = int'(got[20:12]);
    end
    if0.start = s; if0.k_len = k; if0.abort = ab;
    if1.start = s; if1.k_len = k; if1.abort = ab;
    for (int d = 0; d < 2; d++) begin
      exp = model_outs(d, cyc);
      if (ab) begin
        foreach (tq[i]) if (tq[i].d == d && tq[i].cut == INF) tq[i].cut = cyc;
      end else if (s && !exp[24]) begin
        tq.push_back('{d: d, t0: cyc, k: int'(k), cut: INF});
      end
    end
    while (tq.size() > 0 && cyc > tq[0].t0 + tq[0].k + 40) void'(tq.pop_front());
    cyc++;
  endtask

  initial begin
    logic       s, ab;
    logic [8:0] k;
    n_chk = 0; n_pass = 0; cyc = 0;
    for (int d = 0; d < 2; d++) begin
      done_cnt[d] = 0; last_done[d] = -1; last_drain[d] = -1; last_clear[d] = -1; max_rdk[d] = -1;
    end
    if0.start = 0; if0.k_len = '0; if0.abort = 0;
    if1.start = 0; if1.k_len = '0; if1.abort = 0;

    // reset state
    repeat (3) @(negedge clk);
    check("reset_d0", 64'(obs(0)), 64'd0);
    check("reset_d1", 64'(obs(1)), 64'd0);
    rst_n = 1'b1;

    // k_len=3: clear at 1, drain at 13, done at 18 (RD_LAT=1); done at 20 with F=10
    t0 = cyc;
    step(1, 9'd3, 0);
    repeat (30) step(0, 9'd0, 0);
    check("k3_clear_d0", 64'(last_clear[0] - t0), 64'd1);
    check("k3_drain_d0", 64'(last_drain[0] - t0), 64'd13);
    check("k3_done_d0", 64'(last_done[0] - t0), 64'd18);
    check("k3_done_d1", 64'(last_done[1] - t0), 64'd20);
    check("k3_maxrdk_d0", 64'(max_rdk[0]), 64'd2);

    // k_len=0: clear at 1, done at 15 (F=8) / 17 (F=10), no reads
    t0 = cyc; max_rdk[0] = -1;
    step(1, 9'd0, 0);
    repeat (25) step(0, 9'd0, 0);
    check("k0_clear_d0", 64'(last_clear[0] - t0), 64'd1);
    check("k0_done_d0", 64'(last_done[0] - t0), 64'd15);
    check("k0_done_d1", 64'(last_done[1] - t0), 64'd17);
    check("k0_noread_d0", 64'(max_rdk[0]), 64'hFFFF_FFFF_FFFF_FFFF);

    // abort at cycle 4 of a k_len=10 tile, restart at 6 with k_len=5
    t0 = cyc; done_cnt[0] = 0; done_cnt[1] = 0;
    step(1, 9'd10, 0);
    repeat (3) step(0, 9'd0, 0);
    step(0, 9'd0, 1);
    step(0, 9'd0, 0);
    step(1, 9'd5, 0);
    repeat (40) step(0, 9'd0, 0);
    check("abort_dones_d0", 64'(done_cnt[0]), 64'd1);
    check("abort_dones_d1", 64'(done_cnt[1]), 64'd1);
    check("abort_restart_done_d0", 64'(last_done[0] - t0), 64'd26);
    check("abort_restart_done_d1", 64'(last_done[1] - t0), 64'd28);

    // start held high with k_len=2: tiles every 17 (d0) / 19 (d1) cycles
    done_cnt[0] = 0; done_cnt[1] = 0;
    repeat (100) step(1, 9'd2, 0);
    check("held_dones_d0", 64'(done_cnt[0]), 64'd5);
    check("held_dones_d1", 64'(done_cnt[1]), 64'd5);
    repeat (30) step(0, 9'd0, 0);

    // k_len=K_MAX: done at 271 (d0) / 273 (d1), rd_k tops out at 255
    t0 = cyc; max_rdk[0] = -1; max_rdk[1] = -1;
    step(1, 9'd256, 0);
    repeat (290) step(0, 9'd0, 0);
    check("kmax_done_d0", 64'(last_done[0] - t0), 64'd271);
    check("kmax_done_d1", 64'(last_done[1] - t0), 64'd273);
    check("kmax_rdk_d0", 64'(max_rdk[0]), 64'd255);
    check("kmax_rdk_d1", 64'(max_rdk[1]), 64'd255);

    // randomized starts, lengths and aborts
    repeat (1500) begin
      s  = ($urandom % 6) == 0;
      k  = (($urandom % 10) == 0) ? 9'($urandom_range(0, 256)) : 9'($urandom_range(0, 12));
      ab = ($urandom % 50) == 0;
      step(s, k, ab);
    end
    repeat (300) step(0, 9'd0, 0);

    // asynchronous reset mid-tile drops every output without a clock edge
    step(1, 9'd20, 0);
    repeat (5) step(0, 9'd0, 0);
    @(negedge clk);
    check("pre_rst_busy_d0", 64'(if0.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_d0", 64'(obs(0)), 64'd0);
    check("async_rst_d1", 64'(obs(1)), 64'd0);
    tq.delete();
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
